// File: rtl/periph_pkg.sv
// Shared peripheral address map, FSM state type and address-decode helper
// for the peripheral bus arbiter.
package periph_pkg;

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_CTRL    = 32'h4000_0004;
    localparam logic [31:0] ADDR_STAT    = 32'h4000_0008;
    localparam logic [31:0] ADDR_DATA    = 32'h4000_000C;
    localparam logic [31:0] ADDR_IRQ     = 32'h4000_0010;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Only word-aligned registers inside the TH..SYSTICK window decode.
    function automatic logic addr_legal(input logic [31:0] a);
        return (a >= ADDR_TH) && (a <= ADDR_SYSTICK) && (a[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/periph_bus_arbiter_if.sv
// Two-master request/response bus plus the single peripheral port.
// Index i of every per-master vector belongs to master i.
interface periph_bus_arbiter_if;

    logic [1:0]       m_req;
    logic [1:0]       m_we;
    logic [1:0][31:0] m_addr;
    logic [1:0][31:0] m_wdata;
    logic [1:0]       m_gnt;
    logic [1:0]       m_done;
    logic [1:0]       m_err;
    logic [1:0][31:0] m_rdata;

    logic             s_read;
    logic             s_write;
    logic [31:0]      s_addr;
    logic [31:0]      s_wdata;
    logic [31:0]      s_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, s_rdata,
        output m_gnt, m_done, m_err, m_rdata, s_read, s_write, s_addr, s_wdata
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, s_rdata,
        input  m_gnt, m_done, m_err, m_rdata, s_read, s_write, s_addr, s_wdata
    );

endinterface

// File: rtl/arb_pick.sv
// Combinational two-way winner selection; on contention the master that
// was not served last wins.
module arb_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) gnt_o = last_i ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master peripheral bus arbiter: IDLE -> ACCESS -> DONE, one cycle each.
// Define PERIPH_ARB_RR_EN for round-robin contention; default is master0 priority.
module periph_bus_arbiter
    import periph_pkg::*;
(
    input logic               clk,
    input logic               reset,
    periph_bus_arbiter_if.slave bus
);

    state_e           state_q;
    logic [1:0]       gnt_q;
    logic [1:0]       done_q;
    logic [1:0]       err_q;
    logic [1:0][31:0] rdata_q;
    logic             s_read_q;
    logic             s_write_q;
    logic [31:0]      s_addr_q;
    logic [31:0]      s_wdata_q;
    logic             win_q;
    logic             we_q;
    logic             legal_q;

    logic [1:0]       pick_d;
    logic             win_d;
    logic             legal_d;
    logic             last_srv;

`ifdef PERIPH_ARB_RR_EN
    logic last_q;
    assign last_srv = last_q;
`else
    // Pretending master1 was always served last gives master0 fixed priority.
    assign last_srv = 1'b1;
`endif

    arb_pick u_pick (
        .req_i  (bus.m_req),
        .last_i (last_srv),
        .gnt_o  (pick_d)
    );

    assign win_d   = pick_d[1];
    assign legal_d = addr_legal(bus.m_addr[win_d]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
            s_read_q  <= 1'b0;
            s_write_q <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            legal_q   <= 1'b0;
`ifdef PERIPH_ARB_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|bus.m_req) begin
                        state_q   <= ST_ACCESS;
                        gnt_q     <= pick_d;
                        win_q     <= win_d;
                        we_q      <= bus.m_we[win_d];
                        legal_q   <= legal_d;
                        s_addr_q  <= bus.m_addr[win_d];
                        s_wdata_q <= bus.m_wdata[win_d];
                        s_read_q  <= legal_d & ~bus.m_we[win_d];
                        s_write_q <= legal_d &  bus.m_we[win_d];
`ifdef PERIPH_ARB_RR_EN
                        last_q    <= win_d;
`endif
                    end
                end
                ST_ACCESS: begin
                    // Peripheral read data is combinational, so it is valid at this edge.
                    state_q         <= ST_DONE;
                    s_read_q        <= 1'b0;
                    s_write_q       <= 1'b0;
                    s_addr_q        <= '0;
                    s_wdata_q       <= '0;
                    done_q[win_q]   <= 1'b1;
                    err_q[win_q]    <= ~legal_q;
                    rdata_q[win_q]  <= (legal_q && !we_q) ? bus.s_rdata : 32'h0;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.m_gnt   = gnt_q;
    assign bus.m_done  = done_q;
    assign bus.m_err   = err_q;
    assign bus.m_rdata = rdata_q;
    assign bus.s_read  = s_read_q;
    assign bus.s_write = s_write_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_wdata = s_wdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench: transaction-schedule reference model compared every
// cycle, directed literal scenarios, then randomized two-master traffic.
module tb_periph_bus_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    periph_bus_arbiter_if bus ();

    periph_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef PERIPH_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    bit rd_fixed = 1'b0;

    function automatic logic [31:0] periph_val(input logic [31:0] a, input bit fixed);
        return fixed ? 32'h0000_1234 : ((a * 32'h9E37_79B1) ^ 32'hC0FF_EE00);
    endfunction

    function automatic bit legal(input logic [31:0] a);
        return (a >= 32'h4000_0000) && (a <= 32'h4000_0014) && (a % 4 == 0);
    endfunction

    assign bus.s_rdata = periph_val(bus.s_addr, rd_fixed);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a transaction granted at edge T shows its grant and
    // strobe in the cycle after T, its done after T+1; next sampling at T+3.
    int               m_edge;
    int               free_at;
    bit               act;
    int               tg;
    int               w;
    bit               mlast;
    bit               mwe;
    logic [31:0]      maddr, mwdata;
    logic [1:0]       e_gnt, e_done, e_err;
    logic [31:0]      e_rdata [2];
    bit               e_rd, e_wr;
    logic [31:0]      e_saddr, e_swdata;

    task automatic model_init();
        m_edge = 0; free_at = 0; act = 0; tg = 0; w = 0; mlast = 1'b1;
        e_gnt = '0; e_done = '0; e_err = '0; e_rdata[0] = '0; e_rdata[1] = '0;
        e_rd = 0; e_wr = 0; e_saddr = '0; e_swdata = '0;
    endtask

    task automatic model_step();
        m_edge++;
        e_gnt = '0; e_done = '0; e_rd = 0; e_wr = 0; e_saddr = '0; e_swdata = '0;
        if (act && m_edge == tg + 1) begin
            e_done[w]  = 1'b1;
            e_err[w]   = !legal(maddr);
            e_rdata[w] = (legal(maddr) && !mwe) ? periph_val(maddr, rd_fixed) : 32'h0;
            act = 0;
        end
        if (m_edge >= free_at && bus.m_req != 2'b00) begin
            if (bus.m_req == 2'b11) w = (RR && !mlast) ? 1 : 0;
            else                    w = bus.m_req[1] ? 1 : 0;
            mlast   = (w == 1);
            mwe     = bus.m_we[w];
            maddr   = bus.m_addr[w];
            mwdata  = bus.m_wdata[w];
            act     = 1; tg = m_edge; free_at = m_edge + 3;
            e_gnt[w] = 1'b1;
            e_saddr  = maddr;
            e_swdata = mwdata;
            e_rd     = legal(maddr) && !mwe;
            e_wr     = legal(maddr) &&  mwe;
        end
    endtask

    initial begin
        model_init();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_init();
            else       model_step();
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("gnt",    32'(bus.m_gnt),   32'(e_gnt));
            chk("done",   32'(bus.m_done),  32'(e_done));
            chk("err",    32'(bus.m_err),   32'(e_err));
            chk("rdata0", bus.m_rdata[0],   e_rdata[0]);
            chk("rdata1", bus.m_rdata[1],   e_rdata[1]);
            chk("s_read", 32'(bus.s_read),  32'(e_rd));
            chk("s_write",32'(bus.s_write), 32'(e_wr));
            chk("s_addr", bus.s_addr,       e_saddr);
            chk("s_wdata",bus.s_wdata,      e_swdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    logic [1:0]  o_gnt, o_done, o_err;
    logic        o_rd, o_wr, o_strobe2;
    logic [31:0] o_saddr, o_swdata, o_rdata;

    // Called at a negedge; returns at the negedge of the following idle cycle.
    task automatic issue(input int i, input bit we, input logic [31:0] a, input logic [31:0] d);
        bus.m_we[i] = we; bus.m_addr[i] = a; bus.m_wdata[i] = d; bus.m_req[i] = 1'b1;
        @(negedge clk);
        o_gnt = bus.m_gnt; o_rd = bus.s_read; o_wr = bus.s_write;
        o_saddr = bus.s_addr; o_swdata = bus.s_wdata;
        @(negedge clk);
        o_done = bus.m_done; o_err = bus.m_err; o_rdata = bus.m_rdata[i];
        o_strobe2 = bus.s_read | bus.s_write;
        bus.m_req[i] = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] rnd_addr;
    int          n0, g;
    bit          bad;
    int          got [4];
    int          ng;

    initial begin
        bus.m_req = '0; bus.m_we = '0; bus.m_addr = '0; bus.m_wdata = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_gnt",    32'(bus.m_gnt),  32'h0);
        chk("rst_done",   32'(bus.m_done), 32'h0);
        chk("rst_sread",  32'(bus.s_read), 32'h0);
        chk("rst_saddr",  bus.s_addr,      32'h0);
        chk("rst_rdata0", bus.m_rdata[0],  32'h0);

        // m0 read of SYSTICK with fixed peripheral data
        rd_fixed = 1'b1;
        issue(0, 1'b0, 32'h4000_0014, 32'h0);
        rd_fixed = 1'b0;
        chk("a_gnt",     32'(o_gnt),      32'h1);
        chk("a_sread",   32'(o_rd),       32'h1);
        chk("a_swrite",  32'(o_wr),       32'h0);
        chk("a_saddr",   o_saddr,         32'h4000_0014);
        chk("a_strobe2", 32'(o_strobe2),  32'h0);
        chk("a_done",    32'(o_done),     32'h1);
        chk("a_rdata",   o_rdata,         32'h0000_1234);
        chk("a_err",     32'(o_err[0]),   32'h0);

        // m1 write
        issue(1, 1'b1, 32'h4000_000C, 32'h0000_00A5);
        chk("b_gnt",    32'(o_gnt),    32'h2);
        chk("b_swrite", 32'(o_wr),     32'h1);
        chk("b_sread",  32'(o_rd),     32'h0);
        chk("b_saddr",  o_saddr,       32'h4000_000C);
        chk("b_swdata", o_swdata,      32'h0000_00A5);
        chk("b_done",   32'(o_done),   32'h2);
        chk("b_rdata",  o_rdata,       32'h0);
        chk("b_err",    32'(o_err[1]), 32'h0);

        // illegal addresses: past SYSTICK and misaligned
        issue(0, 1'b0, 32'h4000_0018, 32'h0);
        chk("c1_strobe", 32'(o_rd | o_wr), 32'h0);
        chk("c1_done",   32'(o_done),      32'h1);
        chk("c1_err",    32'(o_err[0]),    32'h1);
        issue(0, 1'b0, 32'h4000_0002, 32'h0);
        chk("c2_strobe", 32'(o_rd | o_wr), 32'h0);
        chk("c2_err",    32'(o_err[0]),    32'h1);

        // m1 requests while m0 is in ACCESS
        bus.m_we[0] = 1'b0; bus.m_addr[0] = 32'h4000_0000; bus.m_req[0] = 1'b1;
        n0 = cyc + 1;
        g = -1000;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.m_we[1] = 1'b1; bus.m_addr[1] = 32'h4000_0004;
                bus.m_wdata[1] = 32'hDEAD_0001; bus.m_req[1] = 1'b1;
            end
            if (bus.m_done[0]) bus.m_req[0] = 1'b0;
            if (bus.m_gnt[1] && g < 0) g = cyc + 1;
            if (bus.m_done[1]) begin
                bus.m_req[1] = 1'b0;
                break;
            end
        end
        bus.m_req = '0;
        chk("d_gnt1_latency", 32'(g - n0), 32'd4);
        @(negedge clk);

        // reset during ACCESS
        bus.m_we[0] = 1'b0; bus.m_addr[0] = 32'h4000_0008; bus.m_req[0] = 1'b1;
        @(negedge clk);
        chk("e_sread_pre", 32'(bus.s_read), 32'h1);
        #1 reset = 1'b1; bus.m_req = '0;
        #1;
        chk("e_sread_rst", 32'(bus.s_read), 32'h0);
        chk("e_saddr_rst", bus.s_addr,      32'h0);
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.m_done != 2'b00) bad = 1'b1;
        end
        chk("e_nodone", 32'(bad), 32'h0);

        // continuous contention from both masters
        bus.m_we = 2'b00;
        bus.m_addr[0] = 32'h4000_0010; bus.m_addr[1] = 32'h4000_0004;
        bus.m_req = 2'b11;
        ng = 0;
        for (int j = 0; j < 4; j++) got[j] = 9;
        for (int k = 0; k < 20 && ng < 4; k++) begin
            @(negedge clk);
            if (bus.m_gnt != 2'b00) begin
                got[ng] = bus.m_gnt[1] ? 1 : 0;
                ng++;
            end
        end
        bus.m_req = '0;
        for (int j = 0; j < 4; j++)
            chk($sformatf("f_grant%0d", j), 32'(got[j]), (RR && (j % 2 == 1)) ? 32'd1 : 32'd0);
        repeat (4) @(negedge clk);

        // randomized traffic from both masters
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (bus.m_req[i] && bus.m_done[i]) begin
                    bus.m_req[i] = 1'b0;
                end else if (!bus.m_req[i] && $urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 9))
                        7:       rnd_addr = 32'h4000_0018;
                        8:       rnd_addr = 32'h4000_0000 | 32'($urandom_range(1, 3));
                        9:       rnd_addr = $urandom;
                        default: rnd_addr = 32'h4000_0000 + 32'(4 * $urandom_range(0, 5));
                    endcase
                    bus.m_we[i]    = 1'($urandom_range(0, 1));
                    bus.m_addr[i]  = rnd_addr;
                    bus.m_wdata[i] = $urandom;
                    bus.m_req[i]   = 1'b1;
                end
            end
        end
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (bus.m_done[i]) bus.m_req[i] = 1'b0;
        end
        bus.m_req = '0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
